spi_reg_sequencer: RTL and testbench

Command and transaction sequencer for the accelerometer register interface, clocked directly in the SPI clock domain. It decodes a command byte of the form R/W, auto-increment, and 6-bit address from the MOSI bit stream, then sequences one or more data bytes. It drives an asynchronous-read, `w_SPI_CLK`-write register-file port, and produces the MISO bit stream for reads. It sits between the SPI pins and the register bank; MISO tri-stating stays at top level.

---
 rtl/spi_reg_pkg.sv | 14 +
 rtl/spi_reg_sequencer.sv | 115 +++++++++++
 tb/tb_spi_reg_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types and command-byte layout for the SPI register sequencer.
package spi_reg_pkg;

    typedef enum logic {
        CMD  = 1'b0,
        DATA = 1'b1
    } seq_state_t;

    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_INC_BIT  = 6;
    localparam int CMD_ADDR_MSB = 5;
    localparam int REG_ADDR_W   = 6;

endpackage

// File: rtl/spi_reg_sequencer.sv
// SPI command/transaction sequencer: decodes a command byte (R/W, INC, addr)
// from MOSI, then streams data bytes to/from an async-read register port.
module spi_reg_sequencer
    import spi_reg_pkg::*;
#(
    parameter logic [REG_ADDR_W-1:0] INC_WRAP_HI = 6'h3F,
    parameter logic [REG_ADDR_W-1:0] INC_WRAP_LO = 6'h00
) (
    input  logic                  w_SPI_CLK,
    input  logic                  i_Rst_L,
    input  logic                  i_SPI_CS_n,
    input  logic                  i_SPI_MOSI,
    output logic                  o_SPI_MISO_Bit,
    output logic [REG_ADDR_W-1:0] o_Reg_Addr,
    output logic [7:0]            o_Reg_WData,
    output logic                  o_Reg_WE,
    output logic                  o_Reg_RE,
    input  logic [7:0]            i_Reg_RData,
    output logic                  o_Active,
    output logic                  o_Cmd_Read
);

    seq_state_t            state_reg, state_next;
    logic [2:0]            bit_cnt_reg, bit_cnt_next;
    // Only seven history bits are needed: the eighth bit is always live MOSI.
    logic [6:0]            rx_reg, rx_next;
    logic [7:0]            tx_reg, tx_next;
    logic                  rw_reg, rw_next;
    logic                  inc_reg, inc_next;
    logic [REG_ADDR_W-1:0] addr_reg, addr_next;
    logic                  byte_end;

    // Transaction state; cleared asynchronously by reset or by CS going high.
    always_ff @(posedge w_SPI_CLK or negedge i_Rst_L or posedge i_SPI_CS_n) begin
        if (!i_Rst_L || i_SPI_CS_n) begin
            state_reg   <= CMD;
            bit_cnt_reg <= 3'd0;
            rx_reg      <= 7'd0;
            tx_reg      <= 8'd0;
            rw_reg      <= 1'b0;
            inc_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            rx_reg      <= rx_next;
            tx_reg      <= tx_next;
            rw_reg      <= rw_next;
            inc_reg     <= inc_next;
        end
    end

    // Register address survives CS high so a following access can reuse it.
    always_ff @(posedge w_SPI_CLK or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            addr_reg <= '0;
        end else if (!i_SPI_CS_n) begin
            addr_reg <= addr_next;
        end
    end

    // Next-state, shift, address-advance and strobe/MISO decode.
    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg + 3'd1;
        rx_next        = {rx_reg[5:0], i_SPI_MOSI};
        tx_next        = {tx_reg[6:0], 1'b0};
        rw_next        = rw_reg;
        inc_next       = inc_reg;
        addr_next      = addr_reg;
        byte_end       = (bit_cnt_reg == 3'd7);
        o_Reg_WE       = 1'b0;
        o_Reg_RE       = 1'b0;
        o_Reg_WData    = 8'd0;
        o_SPI_MISO_Bit = 1'b0;

        case (state_reg)
            CMD: begin
                if (byte_end) begin
                    state_next = DATA;
                    rw_next    = rx_reg[CMD_RW_BIT-1];
                    inc_next   = rx_reg[CMD_INC_BIT-1];
                    addr_next  = {rx_reg[CMD_ADDR_MSB-1:0], i_SPI_MOSI};
                end
            end
            DATA: begin
                if (rw_reg) begin
                    o_Reg_RE = byte_end;
                    // First bit of each byte comes straight from the register
                    // port so the MSB is ready as soon as the address settles.
                    if (bit_cnt_reg == 3'd0) begin
                        tx_next        = {i_Reg_RData[6:0], 1'b0};
                        o_SPI_MISO_Bit = i_Reg_RData[7];
                    end else begin
                        o_SPI_MISO_Bit = tx_reg[7];
                    end
                end else begin
                    o_Reg_WE = byte_end;
                    if (byte_end) begin
                        o_Reg_WData = {rx_reg, i_SPI_MOSI};
                    end
                end
                if (byte_end && inc_reg) begin
                    addr_next = (addr_reg == INC_WRAP_HI) ? INC_WRAP_LO
                                                          : addr_reg + 6'd1;
                end
            end
            default: state_next = CMD;
        endcase
    end

    assign o_Reg_Addr = addr_reg;
    assign o_Active   = (state_reg == DATA);
    assign o_Cmd_Read = rw_reg;

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Directed bench for spi_reg_sequencer: bit-level SPI master plus a small
// register-file model; MOSI is driven on negedge, outputs sampled 1ns later.
module tb_spi_reg_sequencer;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic       re;
    logic [7:0] rdata;
    logic       active;
    logic       cmd_read;

    int checks   = 0;
    int failures = 0;

    logic [7:0] regs [64];
    assign rdata = regs[addr];

    spi_reg_sequencer #(
        .INC_WRAP_HI(6'h2D),
        .INC_WRAP_LO(6'h28)
    ) dut (
        .w_SPI_CLK     (clk),
        .i_Rst_L       (rst_l),
        .i_SPI_CS_n    (cs_n),
        .i_SPI_MOSI    (mosi),
        .o_SPI_MISO_Bit(miso),
        .o_Reg_Addr    (addr),
        .o_Reg_WData   (wdata),
        .o_Reg_WE      (we),
        .o_Reg_RE      (re),
        .i_Reg_RData   (rdata),
        .o_Active      (active),
        .o_Cmd_Read    (cmd_read)
    );

    always #5 clk = ~clk;

    // Per-transaction stimulus and capture.
    logic [7:0] tx_bytes   [4];
    logic [7:0] miso_bytes [4];
    int         we_count, re_count;
    logic [5:0] we_addr;
    logic [7:0] we_data;
    int         we_edge;
    logic [5:0] re_addr [4];
    int         re_edge [4];
    logic       active_seen, read_seen;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Clock out nbits of tx_bytes MSB-first; optionally leave CS low at the end.
    task automatic run_txn(input int nbits, input bit keep_cs);
        we_count = 0; re_count = 0; we_addr = '0; we_data = '0; we_edge = 0;
        active_seen = 1'b0; read_seen = 1'b0;
        for (int b = 0; b < 4; b++) begin
            miso_bytes[b] = 8'h00; re_addr[b] = '0; re_edge[b] = 0;
        end
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            cs_n = 1'b0;
            mosi = tx_bytes[i / 8][7 - (i % 8)];
            #1;
            if (i >= 8) miso_bytes[(i - 8) / 8][7 - ((i - 8) % 8)] = miso;
            if (i == 8) begin
                active_seen = active;
                read_seen   = cmd_read;
            end
            if (we) begin
                we_count++; we_addr = addr; we_data = wdata; we_edge = i + 1;
            end
            if (re) begin
                if (re_count < 4) begin
                    re_addr[re_count] = addr; re_edge[re_count] = i + 1;
                end
                re_count++;
            end
        end
        if (!keep_cs) begin
            @(negedge clk);
            cs_n = 1'b1;
            mosi = 1'b0;
            #1;
        end
    endtask

    initial begin
        for (int r = 0; r < 64; r++) regs[r] = 8'(r);
        rst_l = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        #12;
        check_val("rst_addr",  32'(addr), 32'h0);
        check_val("rst_we",    32'(we), 32'h0);
        check_val("rst_re",    32'(re), 32'h0);
        check_val("rst_active", 32'(active), 32'h0);
        check_val("rst_cmdrd", 32'(cmd_read), 32'h0);
        check_val("rst_miso",  32'(miso), 32'h0);
        check_val("rst_wdata", 32'(wdata), 32'h0);
        @(negedge clk); rst_l = 1'b1;
        $display("txn reset: checked reset outputs");

        // Single write 0x20 <- 0x47
        tx_bytes[0] = 8'h20; tx_bytes[1] = 8'h47;
        run_txn(16, 1'b0);
        check_val("wr_we_count", 32'(we_count), 32'd1);
        check_val("wr_addr",     32'(we_addr), 32'h20);
        check_val("wr_data",     32'(we_data), 32'h47);
        check_val("wr_edge",     32'(we_edge), 32'd16);
        check_val("wr_re_count", 32'(re_count), 32'd0);
        check_val("wr_active",   32'(active_seen), 32'd1);
        check_val("wr_idle",     32'(active), 32'd0);
        $display("txn write cmd=0x20 data=0x47: we=%0d addr=0x%0h wdata=0x%0h edge=%0d", we_count, we_addr, we_data, we_edge);

        // Burst read with wrap 0x2C -> 0x2D -> 0x28
        regs[6'h2C] = 8'hA5; regs[6'h2D] = 8'h3C; regs[6'h28] = 8'h96;
        tx_bytes[0] = 8'hEC; tx_bytes[1] = 8'h00; tx_bytes[2] = 8'h00; tx_bytes[3] = 8'h00;
        run_txn(32, 1'b0);
        check_val("br_cmd_read", 32'(read_seen), 32'd1);
        check_val("br_re_count", 32'(re_count), 32'd3);
        check_val("br_addr0", 32'(re_addr[0]), 32'h2C);
        check_val("br_addr1", 32'(re_addr[1]), 32'h2D);
        check_val("br_addr2", 32'(re_addr[2]), 32'h28);
        check_val("br_edge0", 32'(re_edge[0]), 32'd16);
        check_val("br_edge1", 32'(re_edge[1]), 32'd24);
        check_val("br_edge2", 32'(re_edge[2]), 32'd32);
        check_val("br_miso0", 32'(miso_bytes[0]), 32'hA5);
        check_val("br_miso1", 32'(miso_bytes[1]), 32'h3C);
        check_val("br_miso2", 32'(miso_bytes[2]), 32'h96);
        check_val("br_we_count", 32'(we_count), 32'd0);
        check_val("br_addr_end", 32'(addr), 32'h29);
        check_val("br_cmdrd_clr", 32'(cmd_read), 32'd0);
        $display("txn burst read cmd=0xEC: re=%0d miso=%02h %02h %02h", re_count, miso_bytes[0], miso_bytes[1], miso_bytes[2]);

        // Non-increment read of 0x0F
        regs[6'h0F] = 8'h33;
        tx_bytes[0] = 8'h8F;
        run_txn(32, 1'b0);
        check_val("ni_re_count", 32'(re_count), 32'd3);
        check_val("ni_miso0", 32'(miso_bytes[0]), 32'h33);
        check_val("ni_miso1", 32'(miso_bytes[1]), 32'h33);
        check_val("ni_miso2", 32'(miso_bytes[2]), 32'h33);
        check_val("ni_addr2", 32'(re_addr[2]), 32'h0F);
        check_val("ni_addr_end", 32'(addr), 32'h0F);
        $display("txn noinc read cmd=0x8F: re=%0d miso=%02h %02h %02h", re_count, miso_bytes[0], miso_bytes[1], miso_bytes[2]);

        // Aborted write: 5 data bits only
        tx_bytes[0] = 8'h05; tx_bytes[1] = 8'hFF;
        run_txn(13, 1'b0);
        check_val("ab_we_count", 32'(we_count), 32'd0);
        check_val("ab_active",   32'(active), 32'd0);
        $display("txn aborted write cmd=0x05: we=%0d", we_count);

        tx_bytes[0] = 8'h06; tx_bytes[1] = 8'hAA;
        run_txn(16, 1'b0);
        check_val("aw_we_count", 32'(we_count), 32'd1);
        check_val("aw_addr",     32'(we_addr), 32'h06);
        check_val("aw_data",     32'(we_data), 32'hAA);
        check_val("aw_edge",     32'(we_edge), 32'd16);
        $display("txn write cmd=0x06 data=0xAA: we=%0d addr=0x%0h wdata=0x%0h", we_count, we_addr, we_data);

        // Abort during the command byte
        tx_bytes[0] = 8'hC9;
        run_txn(4, 1'b0);
        check_val("ac_strobes", 32'(we_count + re_count), 32'd0);
        check_val("ac_addr",    32'(addr), 32'h06);
        check_val("ac_active",  32'(active), 32'd0);
        $display("txn aborted command 0xC9: strobes=%0d addr=0x%0h", we_count + re_count, addr);

        // Reset during data byte 1 of a read burst from 0x03
        regs[6'h04] = 8'hFF;
        tx_bytes[0] = 8'hC3; tx_bytes[1] = 8'h00; tx_bytes[2] = 8'h00;
        run_txn(19, 1'b1);
        check_val("rm_pre_active", 32'(active), 32'd1);
        check_val("rm_pre_miso",   32'(miso), 32'd1);
        check_val("rm_pre_addr",   32'(addr), 32'h04);
        #1;
        rst_l = 1'b0;
        #1;
        check_val("rm_addr",   32'(addr), 32'h0);
        check_val("rm_miso",   32'(miso), 32'd0);
        check_val("rm_active", 32'(active), 32'd0);
        cs_n = 1'b1;
        @(negedge clk); rst_l = 1'b1;
        $display("txn reset mid-read cmd=0xC3: addr=0x%0h active=%0d", addr, active);

        tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h5A;
        run_txn(16, 1'b0);
        check_val("pr_we_count", 32'(we_count), 32'd1);
        check_val("pr_addr",     32'(we_addr), 32'h11);
        check_val("pr_data",     32'(we_data), 32'h5A);
        $display("txn write after reset cmd=0x11 data=0x5A: we=%0d addr=0x%0h wdata=0x%0h", we_count, we_addr, we_data);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
